// File: rtl/acc_alu_ctrl_pkg.sv
// Shared constants for the accumulator/ALU controller: control-word bit map,
// opcode classes, ALU selects and FSM states.
package acc_alu_ctrl_pkg;

  localparam int CTRL_W = 28;

  localparam int CB_ROMRD      = 0;
  localparam int CB_ROMCS      = 1;
  localparam int CB_PCHBUS     = 2;
  localparam int CB_PCLBUS     = 3;
  localparam int CB_PCHCAR     = 4;
  localparam int CB_PCLCAR     = 5;
  localparam int CB_SELDATAPC  = 6;
  localparam int CB_DIRLOAD    = 7;
  localparam int CB_SPCTRL     = 9;
  localparam int CB_SELSP      = 10;
  localparam int CB_ALUSEL_LSB = 11;
  localparam int CB_REGSEL_LSB = 14;
  localparam int CB_OUTLOAD    = 16;
  localparam int CB_INEN       = 17;
  localparam int CB_RAMCS      = 18;
  localparam int CB_RAMRD      = 20;
  localparam int CB_REGLOAD    = 21;
  localparam int CB_REGEN      = 22;
  localparam int CB_ACCLOAD    = 23;
  localparam int CB_ACCEN      = 24;
  localparam int CB_ALUBUFLOAD = 25;
  localparam int CB_ALUEN      = 26;
  localparam int CB_EOI        = 27;

  localparam logic [2:0] OPC_NOP = 3'b000;
  localparam logic [2:0] OPC_LDA = 3'b001;
  localparam logic [2:0] OPC_OUT = 3'b010;
  localparam logic [2:0] OPC_ALU = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_LDR = 3'b101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_DEC = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_EOI   = 2'd3
  } state_t;

endpackage

// File: rtl/acc_alu_ctrl_alu.sv
// Combinational ALU: result, carry/borrow and zero for the eight ALU selects.
module alu_core
  import acc_alu_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    sel,
  output logic [DW-1:0] result,
  output logic          c,
  output logic          z
);

  logic [DW:0] wide;

  // Top bit of the widened add/sub is carry-out, or borrow on wrap-below-zero.
  always_comb begin
    wide = '0;
    case (sel)
      ALU_ADD: wide = {1'b0, a} + {1'b0, b};
      ALU_SUB: wide = {1'b0, a} - {1'b0, b};
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_NOT: wide = {1'b0, ~a};
      ALU_INC: wide = {1'b0, a} + (DW+1)'(1);
      ALU_DEC: wide = {1'b0, a} - (DW+1)'(1);
      default: wide = '0;
    endcase
  end

  assign result = wide[DW-1:0];
  assign c      = wide[DW];
  assign z      = (result == '0);

endmodule

// File: rtl/acc_alu_ctrl.sv
// Accumulator controller: FETCH/EXEC1/EXEC2/EOI sequencer decoding one opcode
// byte into a 28-bit control word, with accumulator, ALU operand and flags.
module acc_alu_ctrl
  import acc_alu_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instruction,
  input  logic [DW-1:0]     bus_in,
  output logic [DW-1:0]     bus_out,
  output logic              bus_oe,
  output logic [CTRL_W-1:0] ctrl_signals,
  output logic              sp_car,
  output logic [DW-1:0]     acc_buffer,
  output logic              flag_c,
  output logic              flag_z
);

  state_t        st, st_nxt;
  logic [7:0]    ir;
  logic [DW-1:0] acc, opb;
  logic          sp_pend;
  logic [2:0]    cls;
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_z;
  logic          unused_ir;

  assign cls       = ir[7:5];
  assign unused_ir = ^ir[4:3];

  alu_core #(.DW(DW)) u_alu (
    .a      (acc),
    .b      (opb),
    .sel    (ir[2:0]),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= ST_FETCH;
      ir      <= '0;
      acc     <= '0;
      opb     <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      sp_pend <= 1'b1;
    end else begin
      st <= st_nxt;
      case (st)
        ST_FETCH: begin
          ir      <= instruction;
          sp_pend <= 1'b0;
        end
        ST_EXEC1: begin
          if (cls == OPC_LDA || cls == OPC_LDR) acc <= bus_in;
          if (cls == OPC_ALU)                   opb <= bus_in;
        end
        ST_EXEC2: begin
          acc    <= alu_res;
          flag_c <= alu_c;
          flag_z <= alu_z;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nxt       = st;
    ctrl_signals = '0;
    bus_oe       = 1'b0;
    case (st)
      ST_FETCH: begin
        ctrl_signals[CB_ROMRD] = 1'b1;
        ctrl_signals[CB_ROMCS] = 1'b1;
        st_nxt                 = ST_EXEC1;
      end
      ST_EXEC1: begin
        st_nxt = ST_EOI;
        case (cls)
          OPC_LDA: begin
            ctrl_signals[CB_INEN]    = 1'b1;
            ctrl_signals[CB_ACCLOAD] = 1'b1;
          end
          OPC_OUT: begin
            ctrl_signals[CB_OUTLOAD] = 1'b1;
            ctrl_signals[CB_ACCEN]   = 1'b1;
            bus_oe                   = 1'b1;
          end
          OPC_ALU: begin
            ctrl_signals[CB_ALUBUFLOAD]        = 1'b1;
            ctrl_signals[CB_ALUSEL_LSB +: 3]   = ir[2:0];
            st_nxt                             = ST_EXEC2;
          end
          OPC_STR: begin
            ctrl_signals[CB_ACCEN]             = 1'b1;
            ctrl_signals[CB_REGLOAD]           = 1'b1;
            ctrl_signals[CB_REGSEL_LSB +: 2]   = ir[1:0];
            bus_oe                             = 1'b1;
          end
          OPC_LDR: begin
            ctrl_signals[CB_REGEN]             = 1'b1;
            ctrl_signals[CB_ACCLOAD]           = 1'b1;
            ctrl_signals[CB_REGSEL_LSB +: 2]   = ir[1:0];
          end
          default: ;  // NOP and reserved classes
        endcase
      end
      ST_EXEC2: begin
        ctrl_signals[CB_ALUEN]           = 1'b1;
        ctrl_signals[CB_ACCLOAD]         = 1'b1;
        ctrl_signals[CB_ALUSEL_LSB +: 3] = ir[2:0];
        st_nxt                           = ST_EOI;
      end
      ST_EOI: begin
        ctrl_signals[CB_EOI] = 1'b1;
        st_nxt               = ST_FETCH;
      end
      default: st_nxt = ST_FETCH;
    endcase
    // Outputs go quiet the moment reset is seen, not one edge later.
    if (reset) begin
      ctrl_signals = '0;
      bus_oe       = 1'b0;
    end
  end

  assign bus_out    = bus_oe ? acc : '0;
  assign sp_car     = sp_pend && (st == ST_FETCH) && !reset;
  assign acc_buffer = acc;

endmodule

// File: tb/tb_acc_alu_ctrl.sv
// Directed bench for acc_alu_ctrl: hand-computed control words, bus and
// accumulator/flag values sampled on the falling edge.
module tb_acc_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  instruction, bus_in, bus_out, acc_buffer;
  logic        bus_oe, sp_car, flag_c, flag_z;
  logic [27:0] ctrl_signals;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] C_FETCH = 32'h3;
  localparam logic [31:0] C_EOI   = 32'h1 << 27;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] sel;
    logic [7:0] r;
    logic       c;
  } vec_t;
  vec_t vt[9];

  acc_alu_ctrl #(.DW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .ctrl_signals (ctrl_signals),
    .sp_car       (sp_car),
    .acc_buffer   (acc_buffer),
    .flag_c       (flag_c),
    .flag_z       (flag_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a FETCH falling edge, ends at the next FETCH falling edge.
  task automatic run(input logic [7:0] ins, input logic [7:0] b);
    logic [2:0] c3;
    c3          = ins[7:5];
    instruction = ins;
    bus_in      = b;
    repeat ((c3 == 3'b011) ? 4 : 3) step();
  endtask

  initial begin
    vt[0] = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1};  // ADD wrap
    vt[1] = '{8'h10, 8'h20, 3'd1, 8'hF0, 1'b1};  // SUB borrow
    vt[2] = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0};  // AND clears carry
    vt[3] = '{8'h0F, 8'h30, 3'd3, 8'h3F, 1'b0};
    vt[4] = '{8'hFF, 8'h0F, 3'd4, 8'hF0, 1'b0};
    vt[5] = '{8'h55, 8'h00, 3'd5, 8'hAA, 1'b0};
    vt[6] = '{8'hFF, 8'h00, 3'd6, 8'h00, 1'b1};  // INC wrap
    vt[7] = '{8'h00, 8'h00, 3'd7, 8'hFF, 1'b1};  // DEC borrow
    vt[8] = '{8'h01, 8'h00, 3'd7, 8'h00, 1'b0};

    reset = 1'b1; instruction = 8'h00; bus_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ctrl", ctrl_signals, 0);
    chk("rst oe", bus_oe, 0);
    chk("rst acc", acc_buffer, 0);
    chk("rst flags", {flag_c, flag_z}, 0);
    reset = 1'b0;

    // LDA 0x5A
    instruction = 8'h20; bus_in = 8'h5A;
    #1;
    chk("lda fetch ctrl", ctrl_signals, C_FETCH);
    chk("lda fetch sp_car", sp_car, 1);
    step();
    chk("lda exec1 ctrl", ctrl_signals, (1 << 17) | (1 << 23));
    chk("lda exec1 sp_car", sp_car, 0);
    chk("lda exec1 oe", bus_oe, 0);
    step();
    chk("lda eoi ctrl", ctrl_signals, C_EOI);
    chk("lda acc", acc_buffer, 8'h5A);
    step();
    chk("lda next fetch", ctrl_signals, C_FETCH);
    chk("second fetch sp_car", sp_car, 0);

    // ADD: 0xF0 + 0x20
    run(8'h20, 8'hF0);
    instruction = 8'h60; bus_in = 8'h20;
    step();
    chk("add exec1 ctrl", ctrl_signals, 1 << 25);
    step();
    chk("add exec2 ctrl", ctrl_signals, (1 << 26) | (1 << 23));
    chk("add exec2 flags held", {flag_c, flag_z}, 0);
    step();
    chk("add eoi ctrl", ctrl_signals, C_EOI);
    chk("add acc", acc_buffer, 8'h10);
    chk("add c", flag_c, 1);
    chk("add z", flag_z, 0);
    step();

    // SUB: 0x33 - 0x33
    run(8'h20, 8'h33);
    instruction = 8'h61; bus_in = 8'h33;
    step();
    chk("sub exec1 ctrl", ctrl_signals, (1 << 25) | (1 << 11));
    repeat (3) step();
    chk("sub acc", acc_buffer, 8'h00);
    chk("sub z", flag_z, 1);
    chk("sub c", flag_c, 0);

    // OUT then STR
    run(8'h20, 8'hA5);
    instruction = 8'h40; bus_in = 8'h00;
    chk("out fetch oe", bus_oe, 0);
    step();
    chk("out exec1 ctrl", ctrl_signals, (1 << 16) | (1 << 24));
    chk("out oe", bus_oe, 1);
    chk("out data", bus_out, 8'hA5);
    step();
    chk("out eoi oe", bus_oe, 0);
    chk("out eoi data", bus_out, 0);
    step();
    instruction = 8'h82;
    step();
    chk("str exec1 ctrl", ctrl_signals, (1 << 24) | (1 << 21) | (2 << 14));
    chk("str oe", bus_oe, 1);
    chk("str data", bus_out, 8'hA5);
    repeat (2) step();

    // LDR r3
    instruction = 8'hA3; bus_in = 8'h77;
    step();
    chk("ldr exec1 ctrl", ctrl_signals, (1 << 22) | (1 << 23) | (3 << 14));
    step();
    chk("ldr acc", acc_buffer, 8'h77);
    step();

    // Reserved class: 3-cycle NOP, state untouched
    instruction = 8'hC0; bus_in = 8'hEE;
    step();
    chk("nop exec1 ctrl", ctrl_signals, 0);
    step();
    chk("nop eoi ctrl", ctrl_signals, C_EOI);
    step();
    chk("nop back to fetch", ctrl_signals, C_FETCH);
    chk("nop acc", acc_buffer, 8'h77);
    chk("nop flags", {flag_c, flag_z}, 2'b01);

    for (int i = 0; i < 9; i++) begin
      run(8'h20, vt[i].a);
      run({5'b01100, vt[i].sel}, vt[i].b);
      chk($sformatf("alu%0d res", i), acc_buffer, vt[i].r);
      chk($sformatf("alu%0d c", i), flag_c, vt[i].c);
      chk($sformatf("alu%0d z", i), flag_z, (vt[i].r == 8'h00));
    end
    chk("alu loop ends in fetch", ctrl_signals, C_FETCH);

    // Reset during ALU EXEC2: 0x80 + 0x90 must not land
    run(8'h20, 8'h80);
    instruction = 8'h60; bus_in = 8'h90;
    repeat (2) step();
    chk("pre-rst exec2 ctrl", ctrl_signals, (1 << 26) | (1 << 23));
    reset = 1'b1;
    #1;
    chk("mid rst ctrl", ctrl_signals, 0);
    chk("mid rst oe", bus_oe, 0);
    step();
    chk("mid rst acc", acc_buffer, 0);
    chk("mid rst flags", {flag_c, flag_z}, 0);
    reset = 1'b0;
    #1;
    chk("post rst fetch ctrl", ctrl_signals, C_FETCH);
    chk("post rst sp_car", sp_car, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
